// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter: widths, opcode
// encodings ({funct7[6:0], funct3[2:0]}), the arbiter FSM state type and a
// small port-index helper.
package alu_pkg;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 10;

  // Opcodes as {funct7[6:0], funct3[2:0]}
  localparam logic [OP_W-1:0] ALU_ADD = 10'h000;
  localparam logic [OP_W-1:0] ALU_SUB = 10'h100;
  localparam logic [OP_W-1:0] ALU_SLL = 10'h001;
  localparam logic [OP_W-1:0] ALU_SLT = 10'h002;
  localparam logic [OP_W-1:0] ALU_XOR = 10'h004;
  localparam logic [OP_W-1:0] ALU_SRL = 10'h005;
  localparam logic [OP_W-1:0] ALU_SRA = 10'h105;
  localparam logic [OP_W-1:0] ALU_OR  = 10'h006;
  localparam logic [OP_W-1:0] ALU_AND = 10'h007;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } alu_arb_state_t;

  // One-hot select vector for a requester index
  function automatic logic [NUM_REQ-1:0] port_onehot(input logic port);
    logic [NUM_REQ-1:0] vec;
    vec       = '0;
    vec[port] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and alu_arbiter.
// The requester side uses the master modport, the arbiter the slave modport.
interface alu_arbiter_if;
  import alu_pkg::*;

  // Request side, one lane per requester
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][OP_W-1:0]   req_opcode;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_num1;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_num2;

  // Response side, shared result register with per-port valid
  logic [NUM_REQ-1:0]             resp_valid;
  logic [NUM_REQ-1:0]             resp_ready;
  logic [DATA_W-1:0]              resp_result;
  logic                           resp_zero;

  modport master (
    output req_valid, req_opcode, req_num1, req_num2, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero
  );

  modport slave (
    input  req_valid, req_opcode, req_num1, req_num2, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero
  );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU. Undefined opcodes (SLTU included) give a
// result of 0, so zero is simply "result equals 0" for every opcode.
module alu
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] num1,
  input  logic [DATA_W-1:0] num2,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic [4:0] shamt;

  assign shamt = num2[4:0];

  // Operation select
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // result unassigned; otherwise synthesis infers a latch.
    result = '0;
    unique case (opcode)
      ALU_ADD: result = num1 + num2;
      ALU_SUB: result = num1 - num2;
      ALU_SLL: result = num1 << shamt;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, $signed(num1) < $signed(num2)};
      ALU_XOR: result = num1 ^ num2;
      ALU_SRL: result = num1 >> shamt;
      ALU_SRA: result = $unsigned($signed(num1) >>> shamt);
      ALU_OR:  result = num1 | num2;
      ALU_AND: result = num1 & num2;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single alu instance. One request is
// accepted in IDLE, its result is registered and held in RESP until the
// owning port takes it.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; left
// undefined, port 0 has fixed priority and no pointer register exists.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  alu_arb_state_t     state;
  logic               own;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [DATA_W-1:0]  result_q;
  logic               zero_q;

  logic               grant;
  logic               accept;

  logic [OP_W-1:0]    alu_opcode;
  logic [DATA_W-1:0]  alu_num1;
  logic [DATA_W-1:0]  alu_num2;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_zero;

`ifdef ALU_ARB_RR_EN
  logic ptr;

  // Round-robin: the port named by ptr wins, the other only if ptr's port is idle
  always_comb begin
    grant = ptr;
    if (!bus.req_valid[ptr]) begin
      grant = ~ptr;
    end
  end

  // After each accept, priority moves to the port that did not win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant;
    end
  end
`else
  // Fixed priority: port 1 only wins when port 0 has nothing to offer
  always_comb begin
    grant = ~bus.req_valid[0];
  end
`endif

  assign accept = (state == IDLE) && bus.req_valid[grant];

  // Ready goes to the granted port only, and only while idle; never
  // depends on resp_ready
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE) begin
      bus.req_ready[grant] = bus.req_valid[grant];
    end
  end

  // The granted port's payload always drives the alu inputs
  always_comb begin
    alu_opcode = bus.req_opcode[grant];
    alu_num1   = bus.req_num1[grant];
    alu_num2   = bus.req_num2[grant];
  end

  alu u_alu (
    .opcode (alu_opcode),
    .num1   (alu_num1),
    .num2   (alu_num2),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Control FSM with registered response outputs; reset drops any pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      own          <= 1'b0;
      resp_valid_q <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values and simulation matches the synthesized flops.
      unique case (state)
        IDLE: begin
          if (accept) begin
            result_q     <= alu_result;
            zero_q       <= alu_zero;
            own          <= grant;
            resp_valid_q <= port_onehot(grant);
            state        <= RESP;
          end
        end
        RESP: begin
          // resp_ready from the non-owner is deliberately ignored
          if (bus.resp_ready[own]) begin
            resp_valid_q <= '0;
            state        <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= '0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = result_q;
  assign bus.resp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by
// random traffic. A request-side model predicts grants and pushes expected
// responses into a scoreboard; a monitor pops and compares whenever the
// arbiter presents a response. Honours ALU_ARB_RR_EN like the design.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written straight from the opcode table: {zero, result}
  function automatic logic [32:0] ref_alu(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int          sh;
    sh = int'(b % 32);
    case (op)
      10'h000: r = a + b;
      10'h100: r = a - b;
      10'h001: r = a << sh;
      10'h002: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      10'h004: r = a ^ b;
      10'h005: r = a >> sh;
      10'h105: r = $unsigned($signed(a) >>> sh);
      10'h006: r = a | b;
      10'h007: r = a & b;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  typedef struct {
    int          port;
    logic [31:0] result;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  logic [1:0] dut_grants[$];

  // Request-side model state
  bit m_busy = 1'b0;
  int m_own  = 0;
  bit m_ptr  = 1'b0;
  int m_g;
  logic [1:0]  m_exp_ready;
  logic [32:0] m_ref;
  exp_t        m_item;

  // Request-side model: predicts req_ready and pushes expected responses
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr  = 1'b0;
      sb.delete();
    end else begin
      if ((bus.req_valid & bus.req_ready) != 2'b00) dut_grants.push_back(bus.req_valid & bus.req_ready);
      if (m_busy) begin
        check("req_ready_while_busy", bus.req_ready, 2'b00);
        if (bus.resp_ready[m_own]) m_busy = 1'b0;
      end else begin
        m_g = -1;
`ifdef ALU_ARB_RR_EN
        if (bus.req_valid[m_ptr]) m_g = int'(m_ptr);
        else if (bus.req_valid[!m_ptr]) m_g = int'(!m_ptr);
`else
        if (bus.req_valid[0]) m_g = 0;
        else if (bus.req_valid[1]) m_g = 1;
`endif
        m_exp_ready = (m_g < 0) ? 2'b00 : (m_g == 0 ? 2'b01 : 2'b10);
        check("req_ready_idle", bus.req_ready, m_exp_ready);
        if (m_g >= 0) begin
          m_ref       = ref_alu(bus.req_opcode[m_g], bus.req_num1[m_g], bus.req_num2[m_g]);
          m_item.port   = m_g;
          m_item.result = m_ref[31:0];
          m_item.zero   = m_ref[32];
          sb.push_back(m_item);
          m_busy = 1'b1;
          m_own  = m_g;
          m_ptr  = (m_g == 0);
        end
      end
    end
  end

  bit   holding = 1'b0;
  exp_t cur;

  // Monitor: pops and compares when a response appears, then checks it is held
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      holding = 1'b0;
    end else begin
      if (!holding) begin
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          check("resp_valid_onehot", bus.resp_valid, (cur.port == 0) ? 2'b01 : 2'b10);
          check("resp_result", bus.resp_result, cur.result);
          check("resp_zero", bus.resp_zero, cur.zero);
          holding = 1'b1;
        end else begin
          check("resp_valid_idle", bus.resp_valid, 2'b00);
        end
      end else begin
        check("resp_valid_held", bus.resp_valid, (cur.port == 0) ? 2'b01 : 2'b10);
        check("resp_result_held", bus.resp_result, cur.result);
        check("resp_zero_held", bus.resp_zero, cur.zero);
      end
      if (holding && bus.resp_ready[cur.port]) holding = 1'b0;
    end
  end

  task automatic set_req(input int p, input bit v, input logic [9:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[p]  = v;
    bus.req_opcode[p] = op;
    bus.req_num1[p]   = a;
    bus.req_num2[p]   = b;
  endtask

  // Wait (bounded) for any request handshake; leaves time at that negedge
  task automatic wait_hs(input string name, output logic [1:0] hs);
    hs = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      if (hs != 2'b00) break;
    end
    if (hs == 2'b00) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no handshake within 20 cycles", name);
    end
  endtask

  logic [9:0] ops[11];
  logic [1:0] hs;
  logic [1:0] drv_hs;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ops = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, 10'h003, 10'h3FF};
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_num1   = '0;
    bus.req_num2   = '0;
    bus.resp_ready = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_resp_valid", bus.resp_valid, 2'b00);
    check("reset_resp_result", bus.resp_result, 32'd0);
    check("reset_resp_zero", bus.resp_zero, 1'b0);
    check("reset_req_ready", bus.req_ready, 2'b00);
    @(posedge clk); #3 rst_n = 1'b1;

    // Reset while a result is pending
    @(posedge clk); #1;
    set_req(0, 1, ALU_ADD, 32'd5, 32'd7);
    bus.resp_ready = 2'b00;
    wait_hs("mid_resp_accept", hs);
    @(posedge clk); #1;
    set_req(0, 0, ALU_ADD, 32'd5, 32'd7);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_resp_valid", bus.resp_valid, 2'b00);
    check("midreset_resp_result", bus.resp_result, 32'd0);
    check("midreset_resp_zero", bus.resp_zero, 1'b0);
    set_req(0, 1, ALU_ADD, 32'd5, 32'd7);
    set_req(1, 1, ALU_XOR, 32'h1234, 32'h00FF);
    bus.resp_ready = 2'b11;
    @(posedge clk); #3 rst_n = 1'b1;
    wait_hs("post_reset_accept", hs);
    check("post_reset_grant_port0", hs, 2'b01);
    @(posedge clk); #1;
    set_req(0, 0, ALU_ADD, 0, 0);
    wait_hs("post_reset_port1", hs);
    @(posedge clk); #1;
    set_req(1, 0, ALU_ADD, 0, 0);
    repeat (3) @(posedge clk);

    // Single op: SUB 3-3
    #1;
    set_req(0, 1, ALU_SUB, 32'd3, 32'd3);
    wait_hs("single_accept", hs);
    @(posedge clk); #1;
    set_req(0, 0, ALU_SUB, 0, 0);
    check("single_resp_valid", bus.resp_valid, 2'b01);
    check("single_result", bus.resp_result, 32'd0);
    check("single_zero", bus.resp_zero, 1'b1);
    @(posedge clk); #1;
    check("single_released", bus.resp_valid, 2'b00);

    // Contention: both ports continuously valid
    @(posedge clk); #1;
    dut_grants.delete();
    set_req(0, 1, ALU_AND, 32'hFFFF0000, 32'h0F0F0F0F);
    set_req(1, 1, ALU_SRA, 32'h80000000, 32'd4);
    repeat (12) @(posedge clk);
    #1;
    set_req(0, 0, ALU_ADD, 0, 0);
    set_req(1, 0, ALU_ADD, 0, 0);
    check("contention_grant_count", dut_grants.size() >= 5, 1'b1);
    for (int i = 1; i < dut_grants.size(); i++) begin
`ifdef ALU_ARB_RR_EN
      check("contention_alternate", dut_grants[i], ~dut_grants[i-1]);
`else
      check("contention_port0_only", dut_grants[i], 2'b01);
`endif
    end
    repeat (3) @(posedge clk);

    // Backpressure: port 1 SLT -1 < 1 held for 5 cycles
    #1;
    bus.resp_ready = 2'b00;
    set_req(1, 1, ALU_SLT, 32'hFFFFFFFF, 32'd1);
    wait_hs("bp_accept", hs);
    check("bp_grant_port1", hs, 2'b10);
    @(posedge clk); #1;
    set_req(1, 0, ALU_SLT, 0, 0);
    set_req(0, 1, ALU_ADD, 32'd1, 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp_result", bus.resp_result, 32'd1);
      check("bp_valid", bus.resp_valid, 2'b10);
      check("bp_req_ready_low", bus.req_ready, 2'b00);
      @(posedge clk); #1;
    end
    bus.resp_ready = 2'b10;
    @(posedge clk); #1;
    check("bp_released", bus.resp_valid, 2'b00);

    // Wrong-port ready: port 0 owns the result, only port 1 says ready
    wait_hs("wp_accept", hs);
    check("wp_grant_port0", hs, 2'b01);
    @(posedge clk); #1;
    set_req(0, 0, ALU_ADD, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("wp_still_resp", bus.resp_valid, 2'b01);
      @(posedge clk); #1;
    end
    bus.resp_ready = 2'b01;
    @(posedge clk); #1;
    check("wp_released", bus.resp_valid, 2'b00);

    // Undefined opcode 10'h003 with 9,4
    bus.resp_ready = 2'b11;
    set_req(0, 1, 10'h003, 32'd9, 32'd4);
    wait_hs("undef_accept", hs);
    @(posedge clk); #1;
    set_req(0, 0, ALU_ADD, 0, 0);
    check("undef_valid", bus.resp_valid, 2'b01);
    check("undef_result", bus.resp_result, 32'd0);
    check("undef_zero", bus.resp_zero, 1'b1);
    @(posedge clk); #1;
    check("undef_released", bus.resp_valid, 2'b00);

    // Random traffic obeying the hold-until-ready rule
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drv_hs = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!bus.req_valid[p] || drv_hs[p]) begin
          logic [31:0] a, b;
          a = $urandom();
          b = $urandom();
          if ($urandom_range(0, 3) == 0) a = b;
          if ($urandom_range(0, 5) == 0) b = 32'h80000000;
          set_req(p, $urandom_range(0, 3) != 0, ops[$urandom_range(0, 10)], a, b);
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_valid[p] = 1'b0;
        end
      end
      bus.resp_ready = 2'($urandom_range(0, 3));
    end

    // Drain
    @(posedge clk); #1;
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b11;
    repeat (4) @(posedge clk);
    #3;
    check("drain_scoreboard_empty", sb.size(), 0);
    check("drain_no_pending", holding, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
